issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 139 +++++++++++++
 tb/tb_issue_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Register scoreboard with two-source writeback arbitration onto a single GPR write port.
// Optional macro SCOREBOARD_BYPASS_EN: zero-latency write port and grant-masked hazard check.
module issue_scoreboard #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_wr,
  input  logic              id_long,
  output logic              id_stall,
  output logic              ex_issue,
  input  logic              wba_valid,
  input  logic [4:0]        wba_rd,
  input  logic [DATA_W-1:0] wba_data,
  output logic              wba_ready,
  input  logic              wbb_valid,
  input  logic [4:0]        wbb_rd,
  input  logic [DATA_W-1:0] wbb_data,
  output logic              wbb_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        long_cnt,
  output logic              wb_err
);

  logic [31:0]       busy;
  logic [31:0]       busy_chk;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;
  logic              prio_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              gnt;
  logic [4:0]        gnt_rd;
  logic [DATA_W-1:0] gnt_data;
  logic              long_inc;
  logic              long_dec;

  // x0 is hard-wired, so its bit is never produced.
  function automatic logic [31:0] reg_bit(input logic en, input logic [4:0] idx);
    logic [31:0] v;
    v = en ? (32'd1 << idx) : 32'd0;
    v[0] = 1'b0;
    return v;
  endfunction

  // ---- stage p0: writeback arbitration (combinational grant) ----
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (wba_valid && wbb_valid) begin
        gnt_a = !prio_b;
        gnt_b = prio_b;
      end else begin
        gnt_a = wba_valid;
        gnt_b = wbb_valid;
      end
    end
  end

  assign wba_ready = gnt_a;
  assign wbb_ready = gnt_b;
  assign gnt       = gnt_a || gnt_b;
  assign gnt_rd    = gnt_b ? wbb_rd   : wba_rd;
  assign gnt_data  = gnt_b ? wbb_data : wba_data;

`ifdef SCOREBOARD_BYPASS_EN
  assign rf_we    = gnt && (gnt_rd != 5'd0);
  assign rf_waddr = gnt ? gnt_rd   : 5'd0;
  assign rf_wdata = gnt ? gnt_data : '0;
  assign clr_vec  = reg_bit(gnt, gnt_rd);
  // The register being written back this cycle is already resolved for decode.
  assign busy_chk = busy & ~clr_vec;
`else
  // ---- stage p1: registered GPR write port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_we <= gnt && (gnt_rd != 5'd0);
      if (gnt) begin
        rf_waddr <= gnt_rd;
        rf_wdata <= gnt_data;
      end
    end
  end

  assign clr_vec  = reg_bit(rf_we, rf_waddr);
  assign busy_chk = busy;
`endif

  // ---- stage p0: decode hazard check ----
  always_comb begin
    id_stall = 1'b0;
    if (id_valid) begin
      id_stall = (id_rs1_used && busy_chk[id_rs1]) ||
                 (id_rs2_used && busy_chk[id_rs2]) ||
                 (id_rd_wr    && busy_chk[id_rd])  ||
                 (id_long     && (long_cnt == 3'd4));
    end
  end

  assign ex_issue = id_valid && !id_stall;
  assign set_vec  = reg_bit(ex_issue && id_rd_wr, id_rd);
  assign long_inc = ex_issue && id_long;
  assign long_dec = gnt_b && (long_cnt != 3'd0);

  // ---- stage p1: scoreboard state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 32'd0;
      long_cnt <= 3'd0;
      prio_b   <= 1'b0;
      wb_err   <= 1'b0;
    end else begin
      // A set landing on the same index as a clear wins.
      busy <= (busy & ~clr_vec) | set_vec;
      if (long_inc && !long_dec)
        long_cnt <= long_cnt + 3'd1;
      else if (long_dec && !long_inc)
        long_cnt <= long_cnt - 3'd1;
      if (wba_valid && wbb_valid)
        prio_b <= gnt_a;
      if (gnt && (gnt_rd != 5'd0) && !busy[gnt_rd])
        wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: directed hazard scenarios plus random traffic
// checked against a behavioural model of register ownership and writeback order.
`timescale 1ns/1ps
module tb_issue_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wr, id_long;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_stall, ex_issue;
  logic        wba_valid, wba_ready, wbb_valid, wbb_ready;
  logic [4:0]  wba_rd, wbb_rd;
  logic [63:0] wba_data, wbb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [2:0]  long_cnt;
  logic        wb_err;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_long(id_long),
    .id_stall(id_stall), .ex_issue(ex_issue),
    .wba_valid(wba_valid), .wba_rd(wba_rd), .wba_data(wba_data), .wba_ready(wba_ready),
    .wbb_valid(wbb_valid), .wbb_rd(wbb_rd), .wbb_data(wbb_data), .wbb_ready(wbb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .long_cnt(long_cnt), .wb_err(wb_err)
  );

  typedef struct {
    int          addr;
    logic [63:0] data;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  bit  armed = 1'b0;

  // Reference model: which registers have an outstanding producer, how many long ops are out.
  bit  m_busy[32];
  int  m_cnt;
  bit  m_prio_b;
  bit  m_err;
  int  m_commit;
  bit  m_issue, m_gnt_a, m_gnt_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit busy_at(input int r, input int mask);
    return m_busy[r] && (r != mask);
  endfunction

  task automatic clr_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wr = 0; id_long = 0;
    wba_valid = 0; wba_rd = 0; wba_data = 0;
    wbb_valid = 0; wbb_rd = 0; wbb_data = 0;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wr, input bit lng);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_rd_wr = wr; id_long = lng;
  endtask

  // One clock: check combinational outputs against the model, then advance the model.
  task automatic step();
    bit ga, gb, g, stall;
    int grd, mask, clr;
    logic [63:0] gdata;
    wr_t w;
    @(negedge clk);
    ga = 0; gb = 0;
    if (!reset) begin
      if (wba_valid && wbb_valid) begin gb = m_prio_b; ga = !m_prio_b; end
      else begin ga = wba_valid; gb = wbb_valid; end
    end
    g = ga || gb;
    grd = gb ? int'(wbb_rd) : int'(wba_rd);
    gdata = gb ? wbb_data : wba_data;
    mask = -1;
`ifdef SCOREBOARD_BYPASS_EN
    if (g) mask = grd;
`endif
    stall = id_valid && ((id_rs1_used && busy_at(int'(id_rs1), mask)) ||
                         (id_rs2_used && busy_at(int'(id_rs2), mask)) ||
                         (id_rd_wr && busy_at(int'(id_rd), mask)) ||
                         (id_long && m_cnt == 4));
    if (armed) begin
      chk("id_stall", id_stall, stall);
      chk("ex_issue", ex_issue, id_valid && !stall);
      chk("wba_ready", wba_ready, ga);
      chk("wbb_ready", wbb_ready, gb);
      chk("long_cnt", long_cnt, m_cnt);
      chk("wb_err", wb_err, m_err);
    end
    m_issue = id_valid && !stall;
    m_gnt_a = ga;
    m_gnt_b = gb;
    if (g && grd != 0) begin
      w.addr = grd; w.data = gdata;
`ifdef SCOREBOARD_BYPASS_EN
      w.due = cyc;
`else
      w.due = cyc + 1;
`endif
      exp_q.push_back(w);
    end
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_cnt = 0; m_prio_b = 0; m_err = 0; m_commit = -1;
    end else begin
      if (g && grd != 0 && !m_busy[grd]) m_err = 1;
`ifdef SCOREBOARD_BYPASS_EN
      clr = g ? grd : -1;
`else
      clr = m_commit;
      m_commit = g ? grd : -1;
`endif
      if (clr > 0) m_busy[clr] = 0;
      if (m_issue && id_rd_wr && id_rd != 0) m_busy[id_rd] = 1;
      m_cnt = m_cnt + ((m_issue && id_long) ? 1 : 0) - ((gb && m_cnt > 0) ? 1 : 0);
      if (wba_valid && wbb_valid) m_prio_b = ga;
    end
    @(posedge clk); #1;
  endtask

  function automatic int pick_busy();
    int l[$];
    for (int r = 1; r < 32; r++) if (m_busy[r]) l.push_back(r);
    if (l.size() == 0 || $urandom_range(0, 9) == 0) return int'($urandom_range(0, 9));
    return l[$urandom_range(0, l.size() - 1)];
  endfunction

  // Monitor: every GPR write must match the oldest expected write, in the expected cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk); #2;
      if (armed) begin
        if (rf_we === 1'b1) begin
          if (exp_q.size() == 0) chk("rf_we_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rf_waddr", rf_waddr, e.addr);
            chk("rf_wdata", rf_wdata, e.data);
            chk("rf_we_cycle", cyc, e.due);
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("rf_we_missing", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    bit done;
    int qa[$], qb[$], order[$];
    int exp_order[4] = '{10, 11, 12, 13};
    clr_in();
    reset = 1;
    step();
    armed = 1;
    step();
    reset = 0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);

    // RAW on x5 through the ALU port
    set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
    stalls = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      clr_in(); set_id(1, 5, 1, 0, 0, 0, 0, 0);
      if (i == 2) begin wba_valid = 1; wba_rd = 5; wba_data = {$urandom, $urandom}; end
      step();
      if (m_issue) done = 1; else stalls++;
    end
    chk("raw_issued", done, 1);
`ifndef SCOREBOARD_BYPASS_EN
    chk("raw_stall_cycles", stalls, 4);
`endif

    // Contention: both ports held valid, grants alternate starting with A
    clr_in();
    set_id(1, 0, 0, 0, 0, 10, 1, 0); step();
    set_id(1, 0, 0, 0, 0, 11, 1, 1); step();
    set_id(1, 0, 0, 0, 0, 12, 1, 0); step();
    set_id(1, 0, 0, 0, 0, 13, 1, 1); step();
    qa = '{10, 12}; qb = '{11, 13};
    for (int i = 0; i < 8 && (qa.size() > 0 || qb.size() > 0); i++) begin
      clr_in();
      if (qa.size() > 0) begin wba_valid = 1; wba_rd = 5'(qa[0]); wba_data = {$urandom, $urandom}; end
      if (qb.size() > 0) begin wbb_valid = 1; wbb_rd = 5'(qb[0]); wbb_data = {$urandom, $urandom}; end
      step();
      if (m_gnt_a) order.push_back(qa.pop_front());
      if (m_gnt_b) order.push_back(qb.pop_front());
    end
    chk("contention_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("contention_order", order[i], exp_order[i]);

    // Long-op limit
    clr_in();
    for (int r = 1; r <= 4; r++) begin set_id(1, 0, 0, 0, 0, r, 1, 1); step(); end
    chk("long_cnt_full", long_cnt, 4);
    set_id(1, 0, 0, 0, 0, 6, 1, 1); #1;
    chk("long_stall", id_stall, 1);
    step();
    wbb_valid = 1; wbb_rd = 1; wbb_data = {$urandom, $urandom}; step();
    wbb_rd = 2; wbb_data = {$urandom, $urandom}; step();
    chk("long_cnt_issue_and_grant", long_cnt, 3);
    clr_in();
    for (int r = 3; r <= 6; r++) begin
      if (r != 5) begin wbb_valid = 1; wbb_rd = 5'(r); wbb_data = {$urandom, $urandom}; step(); end
    end
    clr_in(); step();
    chk("long_cnt_drained", long_cnt, 0);

    // x0 handling
    set_id(1, 0, 0, 0, 0, 0, 1, 0); step();
    clr_in(); wba_valid = 1; wba_rd = 0; wba_data = 64'h1234; step();
    clr_in(); set_id(1, 0, 1, 0, 1, 0, 1, 0); #1;
    chk("x0_no_stall", id_stall, 0);
    step();
    clr_in(); step(); step();
    chk("x0_no_err", wb_err, 0);

    // Writeback to a never-issued register, then reset mid-stall
    wba_valid = 1; wba_rd = 9; wba_data = 64'hdead; step();
    clr_in(); step();
    chk("err_set", wb_err, 1);
    step(); step(); step();
    chk("err_sticky", wb_err, 1);
    set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
    clr_in(); set_id(1, 5, 1, 0, 0, 0, 0, 0); step();
    reset = 1; step();
    reset = 0; #1;
    chk("rst_stall_clear", id_stall, 0);
    chk("rst_err_clear", wb_err, 0);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      clr_in();
      set_id($urandom_range(0, 1), int'($urandom_range(0, 9)), $urandom_range(0, 1),
             int'($urandom_range(0, 9)), $urandom_range(0, 1), int'($urandom_range(0, 9)),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin
        wba_valid = 1; wba_rd = 5'(pick_busy()); wba_data = {$urandom, $urandom};
      end
      if ($urandom_range(0, 2) == 0) begin
        wbb_valid = 1; wbb_rd = 5'(pick_busy()); wbb_data = {$urandom, $urandom};
      end
      reset = (i == 300);
      step();
    end
    reset = 0;
    clr_in();
    for (int i = 0; i < 4; i++) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
